rx_core: RTL and testbench
==========================

// Module: rx_core
// PURPOSE
//  Serial receive stage; the counterpart of TxCore on the same character line.
//  Samples serialIn at mid-bit and deserialises each start/8-data/parity/stop frame.
//  Presents the byte with full/ack flags and sticky error flags to the protocol layer.
//  Uses the same bit-timing and framing controls as TxCore so both share one config register.
// PARAMETERS
//  PARITY        1   1: frame carries a parity bit after the data bits; 0: no parity bit
//  DIV_WIDTH     13  width of clocksPerBit and of the internal bit-timing counter
// PORTS
//  clk           in   1          system clock, all logic on rising edge
//  nReset        in   1          asynchronous active-low reset
//  serialIn      in   1          asynchronous line input, idle high
//  clocksPerBit  in   DIV_WIDTH  bit period in clk cycles (legal range 4..2^DIV_WIDTH-1)
//  stopBit2      in   1          1: check two stop bits; 0: one stop bit
//  oddParity     in   1          1: data+parity must hold an odd number of ones
//  msbFirst      in   1          1: first data bit received is b7; 0: first is b0
//  ackFlags      in   1          pulse: clear full, overrunErr, parityErr, frameErr
//  dataOut       out  8          last received byte
//  full          out  1          dataOut holds an unacknowledged byte
//  run           out  1          a frame is being received (start detected, not yet idle)
//  overrunErr    out  1          sticky: a byte completed while full=1
//  parityErr     out  1          sticky: parity mismatch on a stored byte
//  frameErr      out  1          sticky: a stop bit was sampled low
// BEHAVIOUR
//  Reset: dataOut=0, full=0, run=0, all error flags=0, FSM=IDLE. Internal sync flops reset to 1.
//  serialIn passes a 2-flop synchroniser; all decisions use the synchronised value rxS.
//  The FSM has states IDLE, START, DATA, PARITY, STOP1, STOP2.
//  - IDLE: on a falling edge of rxS, load cnt=clocksPerBit>>1 and go to START; run=1 from the next cycle.
//  - cnt decrements every cycle. A sample is taken when cnt==0, and cnt then reloads clocksPerBit-1.
//  - START: at the sample, rxS=1 is a false start: go to IDLE with run=0 and no flag change.
//    rxS=0 goes to DATA with bitIdx=0.
//  - DATA: 8 samples. Each goes to shift reg at position bitIdx (lsb-first) or 7-bitIdx (msbFirst).
//    After the 8th sample: go to PARITY if PARITY=1, otherwise to STOP1.
//  - PARITY: sample p. Compute err = (^data ^ p) != oddParity.
//  - STOP1: sample. Go to STOP2 if stopBit2=1; otherwise the frame ends.
//  - STOP2: sample. The frame ends.
//  - Frame end, on the last stop-bit sample cycle:
//    if full=0, dataOut<=shift reg, full<=1, parityErr|=err, frameErr|=any stop sample==0.
//    If full=1, dataOut and full are unchanged, overrunErr<=1, and that frame's parity/frame errors are discarded.
//    FSM->IDLE, run<=0. A new start edge is accepted from the next cycle.
//  - frameErr stop bit (line held low): no new start is detected until rxS has returned high.
//  Latency: full rises 2-3 clk after the line edge plus (clocksPerBit>>1) + N*clocksPerBit, where N = 9 + PARITY + stopBit2.
//  ackFlags clears full and all errors next cycle. A frame end in the same cycle as ackFlags wins:
//    the byte is stored, full=1, errors = only the new frame's errors.
//  clocksPerBit, stopBit2, oddParity, msbFirst are sampled live; changing them mid-frame is undefined.
//  Reset mid-frame aborts immediately; no partial byte is ever presented.
// STRUCTURE
//  Shared package/header: FSM state encodings, DATA_BITS=8, and the framing control bundle
//    (clocksPerBit, stopBit2, oddParity, msbFirst) common to TxCore and rx_core.
//  One sub-module: rx_bit_timer (synchroniser, falling-edge detect, cnt with half/full reload, sample strobe).
//  FSM, shift register and flags live in rx_core.
// TESTING (clocksPerBit=8, PARITY=1, TxCore serialOut looped into serialIn unless stated)
//  1 TxCore sends 0x80, even parity, lsb-first -> full=1, dataOut=0x80, all errors 0; ackFlags -> full=0.
//  2 Back-to-back 0x80 then 0x7F with ack between -> two full pulses, dataOut 0x80 then 0x7F, no errors.
//  3 Driven frame 0xA5 with parity bit inverted -> dataOut=0xA5, parityErr=1; next good frame after ack -> parityErr=0.
//  4 Two frames with no ack -> dataOut stays the first byte, overrunErr=1, full=1.
//  5 A low glitch of 3 clk on an idle line -> run pulses then returns 0, full=0, no flags.
//    A stop bit forced low -> frameErr=1.
//  6 msbFirst=1, stopBit2=1, 0x3C -> dataOut=0x3C.
//    nReset asserted mid-DATA -> all outputs 0 at once and the next frame is received cleanly.

Source files
------------

// File: rtl/rx_core_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rx_core_pkg
// Brief   : FSM encodings, frame constants and framing-control bundle shared
//           by the character-line transmit and receive cores.
// Revision: 1.0 - initial release
// ============================================================================
package rx_core_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_t;

    // Framing options held in the common config register (bit period is separate
    // because its width is a per-instance parameter).
    typedef struct packed {
        logic stop_bit2;
        logic odd_parity;
        logic msb_first;
    } frame_ctl_t;

    function automatic logic parity_error(input logic [DATA_BITS-1:0] data,
                                          input logic                 p,
                                          input logic                 odd);
        return (((^data) ^ p) != odd);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module  : rx_bit_timer
// Brief   : Line synchroniser, falling-edge detect and mid-bit sample strobe.
// Revision: 1.0 - initial release
// ============================================================================
module rx_bit_timer #(
    parameter int DIV_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 i_serial,
    input  logic [DIV_WIDTH-1:0] i_clocks_per_bit,
    input  logic                 i_load_half,
    input  logic                 i_active,
    output logic                 o_rxs,
    output logic                 o_fall,
    output logic                 o_sample
);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    logic [DIV_WIDTH-1:0] r_cnt;

    // Sync chain resets to the idle (high) level so reset release is not seen as a start edge.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_serial;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_cnt <= '0;
        end else if (i_load_half) begin
            r_cnt <= i_clocks_per_bit >> 1;
        end else if (i_active) begin
            if (r_cnt == '0)
                r_cnt <= i_clocks_per_bit - DIV_WIDTH'(1);
            else
                r_cnt <= r_cnt - DIV_WIDTH'(1);
        end
    end

    assign o_rxs    = r_sync2;
    assign o_fall   = r_prev & ~r_sync2;
    assign o_sample = i_active && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/rx_core.sv
`default_nettype none
// ============================================================================
// Module  : rx_core
// Brief   : Serial receive stage: start/8-data/parity/stop deserialiser with
//           full/ack handshake and sticky error flags.
// Revision: 1.0 - initial release
// ============================================================================
module rx_core
    import rx_core_pkg::*;
#(
    parameter int PARITY    = 1,
    parameter int DIV_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 serialIn,
    input  logic [DIV_WIDTH-1:0] clocksPerBit,
    input  logic                 stopBit2,
    input  logic                 oddParity,
    input  logic                 msbFirst,
    input  logic                 ackFlags,
    output logic [7:0]           dataOut,
    output logic                 full,
    output logic                 run,
    output logic                 overrunErr,
    output logic                 parityErr,
    output logic                 frameErr
);

    rx_state_t              r_state;
    rx_state_t              w_next;
    frame_ctl_t             w_ctl;
    logic [2:0]             r_bit_idx;
    logic [2:0]             w_pos;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_err;
    logic                   r_stop_err;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_full;
    logic                   r_ovr;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   w_rxs;
    logic                   w_fall;
    logic                   w_sample;
    logic                   w_load_half;
    logic                   w_active;
    logic                   w_frame_end;
    logic                   w_frame_ferr;

    assign w_ctl       = '{stop_bit2: stopBit2, odd_parity: oddParity, msb_first: msbFirst};
    assign w_active    = (r_state != ST_IDLE);
    assign w_load_half = (r_state == ST_IDLE) && w_fall;
    assign w_pos       = w_ctl.msb_first ? (3'(DATA_BITS - 1) - r_bit_idx) : r_bit_idx;

    rx_bit_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_timer (
        .clk              (clk),
        .nReset           (nReset),
        .i_serial         (serialIn),
        .i_clocks_per_bit (clocksPerBit),
        .i_load_half      (w_load_half),
        .i_active         (w_active),
        .o_rxs            (w_rxs),
        .o_fall           (w_fall),
        .o_sample         (w_sample)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_frame_end  = 1'b0;
        w_frame_ferr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall)
                    w_next = ST_START;
            end
            ST_START: begin
                if (w_sample)
                    w_next = w_rxs ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_sample && (r_bit_idx == 3'(DATA_BITS - 1)))
                    w_next = (PARITY != 0) ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: begin
                if (w_sample)
                    w_next = ST_STOP1;
            end
            ST_STOP1: begin
                if (w_sample) begin
                    if (w_ctl.stop_bit2) begin
                        w_next = ST_STOP2;
                    end else begin
                        w_next       = ST_IDLE;
                        w_frame_end  = 1'b1;
                        w_frame_ferr = ~w_rxs;
                    end
                end
            end
            ST_STOP2: begin
                if (w_sample) begin
                    w_next       = ST_IDLE;
                    w_frame_end  = 1'b1;
                    w_frame_ferr = r_stop_err | ~w_rxs;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Per-frame datapath: shift register and this frame's error capture.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
        end else if (w_sample) begin
            case (r_state)
                ST_START: begin
                    r_bit_idx  <= '0;
                    r_par_err  <= 1'b0;
                    r_stop_err <= 1'b0;
                end
                ST_DATA: begin
                    r_shift[w_pos] <= w_rxs;
                    r_bit_idx      <= r_bit_idx + 3'd1;
                end
                ST_PARITY: r_par_err  <= parity_error(r_shift, w_rxs, w_ctl.odd_parity);
                ST_STOP1:  r_stop_err <= ~w_rxs;
                default: ;
            endcase
        end
    end

    // A completing frame takes priority over a simultaneous ack and replaces the flags.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_data <= '0;
            r_full <= 1'b0;
            r_ovr  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
        end else if (w_frame_end && (!r_full || ackFlags)) begin
            r_data <= r_shift;
            r_full <= 1'b1;
            r_ovr  <= ackFlags ? 1'b0 : r_ovr;
            r_perr <= ackFlags ? r_par_err    : (r_perr | r_par_err);
            r_ferr <= ackFlags ? w_frame_ferr : (r_ferr | w_frame_ferr);
        end else if (w_frame_end) begin
            r_ovr <= 1'b1;
        end else if (ackFlags) begin
            r_full <= 1'b0;
            r_ovr  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
        end
    end

    assign dataOut    = r_data;
    assign full       = r_full;
    assign run        = w_active;
    assign overrunErr = r_ovr;
    assign parityErr  = r_perr;
    assign frameErr   = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_rx_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_rx_core
// Brief   : Directed bench for rx_core; frames are bit-banged onto serialIn.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rx_core;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        nReset;
    logic        serialIn;
    logic [12:0] clocksPerBit;
    logic        stopBit2;
    logic        oddParity;
    logic        msbFirst;
    logic        ackFlags;
    logic [7:0]  dataOut;
    logic        full;
    logic        run;
    logic        overrunErr;
    logic        parityErr;
    logic        frameErr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rx_core #(
        .PARITY    (1),
        .DIV_WIDTH (13)
    ) dut (
        .clk          (clk),
        .nReset       (nReset),
        .serialIn     (serialIn),
        .clocksPerBit (clocksPerBit),
        .stopBit2     (stopBit2),
        .oddParity    (oddParity),
        .msbFirst     (msbFirst),
        .ackFlags     (ackFlags),
        .dataOut      (dataOut),
        .full         (full),
        .run          (run),
        .overrunErr   (overrunErr),
        .parityErr    (parityErr),
        .frameErr     (frameErr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic f,
                             input logic ov, input logic pe, input logic fe);
        check({tag, ".data"},    dataOut,    d);
        check({tag, ".full"},    full,       f);
        check({tag, ".overrun"}, overrunErr, ov);
        check({tag, ".parity"},  parityErr,  pe);
        check({tag, ".frame"},   frameErr,   fe);
    endtask

    task automatic bit_out(input logic b);
        serialIn = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_inv,
                              input logic s1_low, input logic s2_low);
        logic p;
        p = (^d) ^ oddParity ^ par_inv;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++)
            bit_out(msbFirst ? d[7 - i] : d[i]);
        bit_out(p);
        bit_out(~s1_low);
        if (stopBit2)
            bit_out(~s2_low);
        serialIn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic ack();
        ackFlags = 1'b1;
        @(negedge clk);
        ackFlags = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen_run;
        nReset       = 1'b0;
        serialIn     = 1'b1;
        clocksPerBit = 13'(CPB);
        stopBit2     = 1'b0;
        oddParity    = 1'b0;
        msbFirst     = 1'b0;
        ackFlags     = 1'b0;
        repeat (3) @(negedge clk);
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.run", run, 1'b0);
        nReset = 1'b1;
        repeat (4) @(negedge clk);

        // basic even parity, lsb-first
        send_frame(8'h80, 1'b0, 1'b0, 1'b0);
        check_out("f80", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        check("f80.run", run, 1'b0);
        ack();
        check("f80.ack_full", full, 1'b0);

        send_frame(8'h7F, 1'b0, 1'b0, 1'b0);
        check_out("f7F", 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0);
        ack();

        // bad parity, then a good frame clears it
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check_out("badpar", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        ack();
        check_out("badpar.ack", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check_out("goodpar", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        ack();

        // odd parity setting
        oddParity = 1'b1;
        send_frame(8'h80, 1'b0, 1'b0, 1'b0);
        check_out("oddpar", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        ack();
        oddParity = 1'b0;

        // overrun: second frame dropped
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        check_out("overrun", 8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        ack();
        check_out("overrun.ack", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3-clk glitch is a false start
        seen_run = 1'b0;
        serialIn = 1'b0;
        repeat (3) @(negedge clk);
        serialIn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (run) seen_run = 1'b1;
            @(negedge clk);
        end
        check("glitch.run_seen", seen_run, 1'b1);
        check("glitch.run_after", run, 1'b0);
        check_out("glitch", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

        // stop bit low
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        check_out("stoplow", 8'h33, 1'b1, 1'b0, 1'b0, 1'b1);
        ack();

        // msb-first, two stop bits
        msbFirst = 1'b1;
        stopBit2 = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check_out("msb3C", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        ack();
        send_frame(8'h5E, 1'b0, 1'b0, 1'b1);
        check_out("stop2low", 8'h5E, 1'b1, 1'b0, 1'b0, 1'b1);
        ack();
        send_frame(8'hC1, 1'b0, 1'b0, 1'b0);
        check_out("msbC1", 8'hC1, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset in the middle of the data bits (byte C1 still unacknowledged)
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        check("midreset.run_before", run, 1'b1);
        nReset = 1'b0;
        #1;
        check_out("midreset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midreset.run", run, 1'b0);
        @(negedge clk);
        serialIn = 1'b1;
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("midreset.idle_run", run, 1'b0);
        send_frame(8'h96, 1'b0, 1'b0, 1'b0);
        check_out("after_reset", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
